// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the two-port line-memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 28;
  localparam int DATA_W_DEF = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_COOL  = 2'd3
  } arb_state_t;

  typedef enum logic {
    SIDE_I = 1'b0,
    SIDE_D = 1'b1
  } side_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/mem_arb_rr2.sv
// rtl/mem_arb_rr2.sv - two-input round-robin picker owning the last-grant history
module mem_arb_rr2
  import mem_arb_pkg::*;
#(
  parameter bit D_FIRST = 1'b1
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  req_i,
  input  logic  req_d,
  input  logic  update,
  output side_t winner,
  output logic  valid
);

  side_t last_side;

  // The history is only consulted while idle, so recording the winner when the
  // transfer starts is equivalent to recording it when the transfer ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_side <= D_FIRST ? SIDE_I : SIDE_D;
    end else if (update) begin
      last_side <= winner;
    end
  end

  always_comb begin
    valid  = req_i | req_d;
    winner = SIDE_I;
    if (req_i && req_d) begin
      winner = (last_side == SIDE_D) ? SIDE_I : SIDE_D;
    end else if (req_d) begin
      winner = SIDE_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one slow line-memory port between the I and D miss paths
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter bit D_FIRST = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [1:0]        grant,
  output logic [CNT_W-1:0]  stall_cycles
);

  arb_state_t state, state_nxt;
  side_t      win;
  side_t      cool_side;
  logic       i_req, d_req;
  logic       win_valid;
  logic       take, done, stall_hit;

  assign i_req   = i_read | i_write;
  assign d_req   = d_read | d_write;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  mem_arb_rr2 #(
    .D_FIRST(D_FIRST)
  ) u_rr (
    .clk    (clk),
    .rst    (rst),
    .req_i  (i_req),
    .req_d  (d_req),
    .update (take),
    .winner (win),
    .valid  (win_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    done      = 1'b0;
    stall_hit = 1'b0;
    i_ready   = 1'b0;
    d_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          take      = 1'b1;
          state_nxt = (win == SIDE_D) ? ST_GNT_D : ST_GNT_I;
        end
      end
      ST_GNT_I: begin
        i_ready   = mem_ready;
        done      = mem_ready;
        stall_hit = d_req;
        if (mem_ready) state_nxt = ST_COOL;
      end
      ST_GNT_D: begin
        d_ready   = mem_ready;
        done      = mem_ready;
        stall_hit = i_req;
        if (mem_ready) state_nxt = ST_COOL;
      end
      ST_COOL: begin
        stall_hit = (cool_side == SIDE_D) ? i_req : d_req;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // A request with both read and write high is carried out as a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      grant     <= GNT_NONE;
      cool_side <= SIDE_I;
    end else if (take) begin
      if (win == SIDE_D) begin
        mem_write <= d_write;
        mem_read  <= d_read & ~d_write;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        grant     <= GNT_D;
      end else begin
        mem_write <= i_write;
        mem_read  <= i_read & ~i_write;
        mem_addr  <= i_addr;
        mem_wdata <= i_wdata;
        grant     <= GNT_I;
      end
      cool_side <= win;
    end else if (done) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      grant     <= GNT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall_hit && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, i_write, d_read, d_write;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write, mem_ready;
  logic [1:0]    grant;
  logic [CW-1:0] stall_cycles;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .D_FIRST(1'b1), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant(grant), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // requesters (index 0 = I, 1 = D)
  bit            rq_on[2], rq_r[2], rq_w[2];
  logic [AW-1:0] rq_a[2];
  logic [DW-1:0] rq_wd[2];
  int            hold[2], gap[2], gmax;
  int            obs_done[2];

  // transaction-level expectation: who is being served, since when, when it finished
  int            cyc, sv_side, sv_start, sv_end, free_from, last_side, m_stall;
  bit            sv_w;
  logic [AW-1:0] sv_a;
  logic [DW-1:0] sv_wd;
  int            grant_log[$];
  int            cyc_err;
  string         err_txt;

  // memory environment
  int            lat, lat_lo, lat_hi, mem_age;
  bit            junk;
  logic [DW-1:0] store [logic [AW-1:0]];

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] rd_model(logic [AW-1:0] a);
    if (store.exists(a)) return store[a];
    return {4{4'h0, a}};
  endfunction

  function automatic void note(string what);
    if (cyc_err == 0) err_txt = $sformatf("%s at cycle %0d", what, cyc);
    cyc_err++;
  endfunction

  task automatic issue(int s, bit w, bit r, logic [AW-1:0] a, logic [DW-1:0] wd);
    rq_on[s] = 1'b1; rq_w[s] = w; rq_r[s] = r; rq_a[s] = a; rq_wd[s] = wd;
  endtask

  task automatic apply_pins();
    i_read  = rq_on[0] & rq_r[0];  i_write = rq_on[0] & rq_w[0];
    i_addr  = rq_a[0];             i_wdata = rq_wd[0];
    d_read  = rq_on[1] & rq_r[1];  d_write = rq_on[1] & rq_w[1];
    d_addr  = rq_a[1];             d_wdata = rq_wd[1];
  endtask

  task automatic set_lat(int lo, int hi);
    lat_lo = lo; lat_hi = hi; lat = $urandom_range(lo, hi);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      rq_on[s] = 0; rq_r[s] = 0; rq_w[s] = 0; rq_a[s] = '0; rq_wd[s] = '0;
      hold[s] = 0; gap[s] = 0; obs_done[s] = 0;
    end
    apply_pins();
    mem_ready = 1'b0; mem_rdata = rnd128(); junk = 0; gmax = 0; mem_age = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    cyc = cyc + 2;
    sv_side = -1; sv_end = -1; sv_start = 0; free_from = cyc;
    last_side = 0; m_stall = 0; cyc_err = 0; err_txt = "";
    grant_log.delete(); store.delete();
  endtask

  // One clock: entered #1 after an edge, returns #1 after the next edge.
  task automatic cycle();
    int            t, win;
    bit            p[2];
    bit            in_srv, free, rdy_i, rdy_d, got_i, got_d;
    logic [1:0]    eg;
    logic [DW-1:0] exp_rd;
    t = cyc;
    apply_pins();
    p[0] = rq_on[0]; p[1] = rq_on[1];
    in_srv = (sv_side >= 0) && (t >= sv_start) && (sv_end < 0);
    eg = !in_srv ? 2'b00 : ((sv_side == 1) ? 2'b10 : 2'b01);
    if (stall_cycles !== CW'(m_stall)) note("stall_cycles");
    if (grant !== eg) note("grant");
    if (mem_read !== (in_srv && !sv_w)) note("mem_read");
    if (mem_write !== (in_srv && sv_w)) note("mem_write");
    if (in_srv && mem_addr !== sv_a) note("mem_addr");
    if (in_srv && sv_w && mem_wdata !== sv_wd) note("mem_wdata");

    exp_rd = rd_model(sv_a);
    mem_ready = 1'b0; mem_rdata = rnd128();
    if (mem_read || mem_write) begin
      if (mem_age >= lat) begin
        mem_ready = 1'b1;
        if (mem_write) store[mem_addr] = mem_wdata;
        else mem_rdata = rd_model(mem_addr);
        mem_age = 0; lat = $urandom_range(lat_lo, lat_hi);
      end else begin
        mem_age++;
      end
    end else if (junk && $urandom_range(0, 3) == 0) begin
      mem_ready = 1'b1;
    end
    #1;
    rdy_i = in_srv && mem_ready && (sv_side == 0);
    rdy_d = in_srv && mem_ready && (sv_side == 1);
    got_i = i_ready; got_d = d_ready;
    if (got_i !== rdy_i) note("i_ready");
    if (got_d !== rdy_d) note("d_ready");
    if (i_rdata !== mem_rdata || d_rdata !== mem_rdata) note("rdata passthrough");
    if (in_srv && mem_ready) begin
      if (!sv_w && ((sv_side == 0) ? i_rdata : d_rdata) !== exp_rd) note("read data");
      sv_end = t;
    end
    if (sv_side >= 0 && (sv_end < 0 || t <= sv_end + 1) && p[1 - sv_side] && m_stall < (1 << CW) - 1)
      m_stall++;

    free = (sv_side < 0) ? (t >= free_from) : (sv_end >= 0 && t >= sv_end + 2);
    if (free && (p[0] || p[1])) begin
      win = (p[0] && p[1]) ? 1 - last_side : (p[1] ? 1 : 0);
      sv_side = win; sv_start = t + 1; sv_end = -1;
      sv_w = rq_w[win]; sv_a = rq_a[win]; sv_wd = rq_wd[win];
      last_side = win;
      grant_log.push_back(win);
    end

    for (int s = 0; s < 2; s++) begin
      if ((s == 0) ? got_i : got_d) begin
        obs_done[s]++; rq_on[s] = 0;
        if (hold[s] > 0) gap[s] = $urandom_range(0, gmax);
      end else if (!rq_on[s] && hold[s] > 0) begin
        if (gap[s] == 0) begin
          bit w;
          w = 1'($urandom_range(0, 1));
          issue(s, w, w ? 1'($urandom_range(0, 1)) : 1'b1, AW'(28'h10 + $urandom_range(0, 7)), rnd128());
          hold[s]--;
        end else begin
          gap[s]--;
        end
      end
    end
    @(posedge clk); #1;
    mem_ready = 1'b0;
    cyc++;
  endtask

  task automatic run_until(int total, int bound, output bit ok);
    ok = 0;
    for (int k = 0; k < bound; k++) begin
      if (obs_done[0] + obs_done[1] >= total) begin ok = 1; break; end
      cycle();
    end
    if (obs_done[0] + obs_done[1] >= total) ok = 1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) $display("FAIL reset_op: read=%0b write=%0b want 0 0", mem_read, mem_write); else n_pass++;
    n_checks++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_data: addr=%h wdata=%h want 0", mem_addr, mem_wdata); else n_pass++;
    n_checks++; if (grant !== 2'b00) $display("FAIL reset_grant: got %b want 00", grant); else n_pass++;
    n_checks++; if (stall_cycles !== '0) $display("FAIL reset_stall: got %0d want 0", stall_cycles); else n_pass++;
    n_checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) $display("FAIL reset_ready: i=%0b d=%0b want 0 0", i_ready, d_ready); else n_pass++;
  endtask

  task automatic test_single_read();
    bit ok, d_seen;
    do_reset(); set_lat(2, 2);
    issue(0, 0, 1, 28'h0000010, '0);
    cycle();
    n_checks++; if (mem_read !== 1'b1 || mem_addr !== 28'h0000010) $display("FAIL single_issue: read=%0b addr=%h want 1 0000010", mem_read, mem_addr); else n_pass++;
    n_checks++; if (grant !== 2'b01) $display("FAIL single_grant: got %b want 01", grant); else n_pass++;
    ok = 0; d_seen = 0;
    for (int k = 0; k < 20 && !ok; k++) begin
      cycle();
      if (obs_done[1] != 0) d_seen = 1;
      if (obs_done[0] != 0) ok = 1;
    end
    n_checks++; if (!ok || d_seen) $display("FAIL single_ready: i_done=%0d d_done=%0d want 1 0", obs_done[0], obs_done[1]); else n_pass++;
    n_checks++; if (grant !== 2'b00 || mem_read !== 1'b0) $display("FAIL single_cool: grant=%b read=%0b want 00 0", grant, mem_read); else n_pass++;
    issue(1, 0, 1, 28'h0000020, '0);
    cycle();
    n_checks++; if (mem_read !== 1'b0 || grant !== 2'b00) $display("FAIL single_idle: read=%0b grant=%b want 0 00", mem_read, grant); else n_pass++;
    cycle();
    n_checks++; if (mem_read !== 1'b1 || grant !== 2'b10) $display("FAIL single_next: read=%0b grant=%b want 1 10", mem_read, grant); else n_pass++;
    run_until(2, 20, ok);
    n_checks++; if (!ok || cyc_err != 0) $display("FAIL single_model: done=%0b deviations=%0d (%s) want 1 0", ok, cyc_err, err_txt); else n_pass++;
  endtask

  task automatic test_tie();
    bit ok;
    logic [DW-1:0] a5;
    a5 = {16{8'hA5}};
    do_reset(); set_lat(3, 3);
    issue(0, 0, 1, 28'h10, '0);
    issue(1, 1, 0, 28'h20, a5);
    cycle();
    n_checks++; if (grant !== 2'b10 || mem_write !== 1'b1 || mem_read !== 1'b0) $display("FAIL tie_first: grant=%b write=%0b read=%0b want 10 1 0", grant, mem_write, mem_read); else n_pass++;
    n_checks++; if (mem_wdata !== a5 || mem_addr !== 28'h20) $display("FAIL tie_data: addr=%h wdata=%h want 20 a5..", mem_addr, mem_wdata); else n_pass++;
    run_until(2, 40, ok);
    n_checks++; if (!ok || grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 0) $display("FAIL tie_order: done=%0b log_size=%0d want D then I", ok, grant_log.size()); else n_pass++;
    n_checks++; if (stall_cycles !== CW'(3 + 1 + 1)) $display("FAIL tie_stall: got %0d want %0d", stall_cycles, 5); else n_pass++;
    n_checks++; if (cyc_err != 0) $display("FAIL tie_model: %0d deviations (%s) want 0", cyc_err, err_txt); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset(); set_lat(0, 3);
    hold[0] = 2; hold[1] = 2; gmax = 0;
    cycle();
    run_until(4, 80, ok);
    n_checks++; if (!ok || grant_log.size() < 4) $display("FAIL b2b_done: done=%0d want 4", obs_done[0] + obs_done[1]); else n_pass++;
    n_checks++; if (grant_log.size() >= 4 && (grant_log[0] != 1 || grant_log[1] != 0 || grant_log[2] != 1 || grant_log[3] != 0))
      $display("FAIL b2b_order: got %0d%0d%0d%0d want 1010 (1=D)", grant_log[0], grant_log[1], grant_log[2], grant_log[3]); else n_pass++;
    n_checks++; if (cyc_err != 0) $display("FAIL b2b_model: %0d deviations (%s) want 0", cyc_err, err_txt); else n_pass++;
  endtask

  task automatic test_hold_stable();
    bit ok;
    int bad;
    do_reset(); set_lat(4, 4);
    issue(1, 1, 0, 28'h20, rnd128());
    cycle();
    rq_a[1] = 28'h30; rq_w[1] = 0; rq_r[1] = 1;
    issue(0, 0, 1, 28'h10, '0);
    bad = 0;
    for (int k = 0; k < 20 && obs_done[1] == 0; k++) begin
      if (grant === 2'b10 && mem_addr !== 28'h20) bad++;
      if (grant === 2'b10 && mem_write !== 1'b1) bad++;
      cycle();
    end
    n_checks++; if (bad != 0 || obs_done[1] != 1) $display("FAIL hold_latched: unstable=%0d d_done=%0d want 0 1", bad, obs_done[1]); else n_pass++;
    run_until(2, 30, ok);
    n_checks++; if (!ok || grant_log.size() != 2 || grant_log[1] != 0) $display("FAIL hold_next: done=%0b log_size=%0d want I second", ok, grant_log.size()); else n_pass++;
    n_checks++; if (cyc_err != 0) $display("FAIL hold_model: %0d deviations (%s) want 0", cyc_err, err_txt); else n_pass++;
  endtask

  task automatic test_drop();
    bit ok;
    do_reset(); set_lat(3, 3);
    issue(0, 0, 1, 28'h40, '0);
    cycle();
    rq_on[0] = 0;
    run_until(1, 20, ok);
    n_checks++; if (!ok || obs_done[0] != 1) $display("FAIL drop_ready: i_done=%0d want 1", obs_done[0]); else n_pass++;
    cycle(); cycle();
    n_checks++; if (cyc_err != 0 || grant !== 2'b00) $display("FAIL drop_model: %0d deviations (%s) grant=%b want 0 00", cyc_err, err_txt, grant); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset(); set_lat(30, 30);
    issue(0, 0, 1, 28'h60, '0);
    cycle();
    issue(1, 0, 1, 28'h70, '0);
    cycle(); cycle(); cycle();
    n_checks++; if (cyc_err != 0) $display("FAIL rstmid_pre: %0d deviations (%s) want 0", cyc_err, err_txt); else n_pass++;
    rst = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (mem_read !== 1'b0 || grant !== 2'b00) $display("FAIL rstmid_clear: read=%0b grant=%b want 0 00", mem_read, grant); else n_pass++;
    n_checks++; if (stall_cycles !== '0) $display("FAIL rstmid_stall: got %0d want 0", stall_cycles); else n_pass++;
    n_checks++; if (i_ready !== 1'b0 || d_ready !== 1'b0) $display("FAIL rstmid_ready: i=%0b d=%0b want 0 0", i_ready, d_ready); else n_pass++;
    do_reset(); set_lat(1, 1);
    issue(1, 0, 1, 28'h70, '0);
    run_until(1, 20, ok);
    n_checks++; if (!ok || obs_done[1] != 1 || obs_done[0] != 0 || cyc_err != 0)
      $display("FAIL rstmid_after: d_done=%0d i_done=%0d deviations=%0d (%s) want 1 0 0", obs_done[1], obs_done[0], cyc_err, err_txt); else n_pass++;
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset(); set_lat(20, 20);
    issue(1, 1, 1, 28'h50, rnd128());
    issue(0, 0, 1, 28'h10, '0);
    cycle();
    n_checks++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || grant !== 2'b10) $display("FAIL sat_rw_write: write=%0b read=%0b grant=%b want 1 0 10", mem_write, mem_read, grant); else n_pass++;
    set_lat(2, 2); lat = 20;
    run_until(2, 80, ok);
    cycle(); cycle(); cycle();
    n_checks++; if (!ok || stall_cycles !== 4'd15) $display("FAIL sat_hold: done=%0b stall=%0d want 1 15", ok, stall_cycles); else n_pass++;
    n_checks++; if (cyc_err != 0) $display("FAIL sat_model: %0d deviations (%s) want 0", cyc_err, err_txt); else n_pass++;
  endtask

  task automatic test_random();
    bit ok;
    int h0, h1;
    for (int r = 0; r < 3; r++) begin
      do_reset(); set_lat(0, 4);
      h0 = $urandom_range(5, 12); h1 = $urandom_range(5, 12);
      hold[0] = h0; hold[1] = h1; gmax = 3; junk = 1;
      run_until(h0 + h1, 3000, ok);
      cycle(); cycle();
      n_checks++; if (!ok || obs_done[0] != h0 || obs_done[1] != h1) $display("FAIL rand%0d_done: i=%0d/%0d d=%0d/%0d", r, obs_done[0], h0, obs_done[1], h1); else n_pass++;
      n_checks++; if (stall_cycles !== CW'(m_stall)) $display("FAIL rand%0d_stall: got %0d want %0d", r, stall_cycles, m_stall); else n_pass++;
      n_checks++; if (cyc_err != 0) $display("FAIL rand%0d_model: %0d deviations (%s) want 0", r, cyc_err, err_txt); else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 0; mem_ready = 1'b0; mem_rdata = '0;
    i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
    lat_lo = 0; lat_hi = 0; lat = 0;
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_hold_stable();
    test_drop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one slow_memory port between the I-cache miss path and the D-cache miss/writeback path in CHIP.
- This lets the split-memory configuration run on a single external memory, or lets one L2 slice be fed by both L1s.
- Two requesters use the same 128-bit line protocol as slow_memory (read/write/addr[31:4]/wdata/rdata/ready).
- Arbitration is round-robin. The granted request is latched and held stable until mem_ready. A fixed one-cycle turnaround follows each transfer.

Parameters:
ADDR_W, 28, line address width (byte address bits [31:4])
DATA_W, 128, line data width
D_FIRST, 1, 1: D side wins the first tie after reset; 0: I side wins it
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_read  in  1  I-side line read request
i_write  in  1  I-side line write request
i_addr  in  ADDR_W  I-side line address
i_wdata  in  DATA_W  I-side write data
i_rdata  out  DATA_W  read data to I side
i_ready  out  1  I-side completion pulse
d_read  in  1  D-side line read request
d_write  in  1  D-side line write request
d_addr  in  ADDR_W  D-side line address
d_wdata  in  DATA_W  D-side write data
d_rdata  out  DATA_W  read data to D side
d_ready  out  1  D-side completion pulse
mem_read  out  1  read to memory
mem_write  out  1  write to memory
mem_addr  out  ADDR_W  line address to memory
mem_wdata  out  DATA_W  write data to memory
mem_rdata  in  DATA_W  memory read data
mem_ready  in  1  memory completion
grant  out  2  00 none, 01 I, 10 D
stall_cycles  out  CNT_W  saturating count of cycles a requester waited while the other side held the grant

Behaviour:
- Reset:
  - All registered outputs go to 0: mem_read, mem_write, mem_addr, mem_wdata, grant, stall_cycles.
  - last_grant is set so that the first tie goes to D if D_FIRST=1, else to I.
  - State goes to IDLE.
  - rst asserted mid-transfer abandons the transfer; no x_ready pulse is issued.
- States:
  - IDLE: a requester is pending if read|write is high.
    - One side pending: that side wins.
    - Both pending: the side not in last_grant wins.
    - On a win, latch addr, wdata and op into the mem_* registers, set grant, go to GNT_I or GNT_D.
    - Request seen in cycle N gives mem_read/mem_write high in cycle N+1.
  - GNT_I / GNT_D:
    - mem_* outputs are driven only from the latched copy. Requester changes during the grant are ignored.
    - When mem_ready=1, the same cycle pulses x_ready=1 for the granted side only (combinational gating). The other side's ready stays 0.
    - The next edge clears mem_read, mem_write and grant, updates last_grant, and goes to COOL.
  - COOL: exactly one cycle with no request driven, so caches can drop their request. Then IDLE. No arbitration happens in COOL.
- Data return: i_rdata and d_rdata both equal mem_rdata at all times. Caches sample only on their own ready.
- Minimum cost per transfer: memory latency + 3 cycles (latch, ready, COOL).
- A requester with read and write both high is serviced as a write; read is ignored.
- A requester that drops its request mid-grant still gets its transfer completed and its ready pulsed.
- mem_ready while in IDLE or COOL is ignored.
- stall_cycles increments each cycle where state is GNT_x (or COOL following it) and the other side is pending. It saturates at 2^CNT_W-1 and never wraps.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, GNT_I, GNT_D, COOL}
  - grant constants GNT_NONE=2'b00, GNT_I=2'b01, GNT_D=2'b10
  - default ADDR_W and DATA_W
- One sub-module, mem_arb_rr2: 2-input round-robin picker holding the last_grant register. Inputs are req_i, req_d and an update strobe; output is the winner.

Test Plan:
1. Reset then i_read=1, i_addr=28'h0000010, D idle:
   - mem_read=1 and mem_addr=28'h0000010 one cycle later.
   - On mem_ready: i_ready=1 for one cycle, d_ready=0.
   - grant returns to 00 and the arbiter is IDLE 2 cycles after ready.
2. D_FIRST=1, same-cycle i_read (addr 0x10) and d_write (addr 0x20, wdata 128'hA5…A5):
   - D served first with mem_write=1 and mem_wdata=A5…A5.
   - I served afterwards.
   - stall_cycles equals the D transfer length + 1.
3. Both sides requesting continuously for 4 transfers -> grant sequence D, I, D, I with a COOL cycle between each.
4. During GNT_D, d_addr changes to 0x30 and i_read rises -> mem_addr stays 0x20 until mem_ready; I is granted only after COOL.
5. rst asserted in the middle of a GNT_I transfer:
   - Next cycle mem_read=0, grant=00, stall_cycles=0, no i_ready pulse.
   - A subsequent d_read is then served normally.
6. CNT_W=4, I held pending through long D transfers -> stall_cycles reaches 15 and holds. d_read and d_write both high -> memory sees a write.
